// File: rtl/sdm_modulator_if.sv
// PCM handshake and bitstream signals for the second-order sigma-delta modulator.
// The master side supplies samples; the slave side is the modulator itself.
interface sdm_modulator_if #(
    parameter int DATA_WIDTH = 16
);
    logic signed [DATA_WIDTH-1:0] din;
    logic                         valid_in;
    logic                         ready_out;
    logic                         bit_out;
    logic                         sample_tick;
    logic                         underrun;

    modport master (
        output din,
        output valid_in,
        input  ready_out,
        input  bit_out,
        input  sample_tick,
        input  underrun
    );

    modport slave (
        input  din,
        input  valid_in,
        output ready_out,
        output bit_out,
        output sample_tick,
        output underrun
    );
endinterface

// File: rtl/sdm_modulator.sv
// Second-order 1-bit sigma-delta modulator (bitstream DAC front end).
// PCM samples arrive over valid/ready once per OSR clocks through a one-entry
// hold buffer; the two saturating integrators run every clk and emit one bit.
module sdm_modulator #(
    parameter int DATA_WIDTH = 16,
    parameter int OSR        = 64,
    parameter int ACC_WIDTH  = 20
) (
    input logic          clk,
    input logic          rst,
    sdm_modulator_if.slave bus
);

    localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
    // Two guard bits: i + x - fb and i2 + i1_n - fb can never overflow before sat().
    localparam int SUM_W = ACC_WIDTH + 2;

    localparam logic signed [SUM_W-1:0] FS_S =
        {{(SUM_W-DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] ACC_MAX_S =
        {3'b000, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN_S =
        {3'b111, {(ACC_WIDTH-1){1'b0}}};

    logic [CNT_W-1:0]              cnt;
    logic                          sample_tick;
    logic                          ready;
    logic                          accept;
    logic                          underrun;

    logic signed [DATA_WIDTH-1:0]  cur;
    logic signed [DATA_WIDTH-1:0]  hold;
    logic                          hold_full;

    logic signed [ACC_WIDTH-1:0]   i1;
    logic signed [ACC_WIDTH-1:0]   i2;
    logic signed [ACC_WIDTH-1:0]   i1_n;
    logic signed [ACC_WIDTH-1:0]   i2_n;
    logic                          bit_q;

    logic signed [SUM_W-1:0]       fb;
    logic signed [SUM_W-1:0]       x_s;
    logic signed [SUM_W-1:0]       i1_s;
    logic signed [SUM_W-1:0]       i1_n_s;
    logic signed [SUM_W-1:0]       i2_s;
    logic signed [SUM_W-1:0]       i1_sum;
    logic signed [SUM_W-1:0]       i2_sum;

    // Clamp a guard-extended sum back into the integrator range.
    function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [SUM_W-1:0] v);
        logic signed [ACC_WIDTH-1:0] r;
        if (v > ACC_MAX_S) begin
            r = ACC_MAX_S[ACC_WIDTH-1:0];
        end else if (v < ACC_MIN_S) begin
            r = ACC_MIN_S[ACC_WIDTH-1:0];
        end else begin
            r = v[ACC_WIDTH-1:0];
        end
        return r;
    endfunction

    // Frame control: tick on the last cycle, handshake and underrun flag.
    always_comb begin
        sample_tick = (cnt == CNT_W'(OSR - 1));
        ready       = !hold_full || sample_tick;
        accept      = bus.valid_in && ready;
        underrun    = sample_tick && !hold_full && !accept;
    end

    assign bus.ready_out   = ready;
    assign bus.sample_tick = sample_tick;
    assign bus.underrun    = underrun;
    assign bus.bit_out     = bit_q;

    // Frame counter, free running 0..OSR-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (sample_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sample path: one-entry hold buffer in front of the modulator input.
    // At a tick with an empty buffer, an incoming sample bypasses straight to cur.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (sample_tick) begin
            if (hold_full) begin
                cur <= hold;
                if (accept) begin
                    hold <= bus.din;
                end else begin
                    hold_full <= 1'b0;
                end
            end else if (accept) begin
                cur <= bus.din;
            end
        end else if (accept) begin
            hold      <= bus.din;
            hold_full <= 1'b1;
        end
    end

    // Integrator arithmetic; i2 consumes the freshly updated i1.
    always_comb begin
        fb     = bit_q ? FS_S : -FS_S;
        x_s    = {{(SUM_W-DATA_WIDTH){cur[DATA_WIDTH-1]}}, cur};
        i1_s   = {{2{i1[ACC_WIDTH-1]}}, i1};
        i2_s   = {{2{i2[ACC_WIDTH-1]}}, i2};
        i1_sum = i1_s + x_s - fb;
        i1_n   = sat(i1_sum);
        i1_n_s = {{2{i1_n[ACC_WIDTH-1]}}, i1_n};
        i2_sum = i2_s + i1_n_s - fb;
        i2_n   = sat(i2_sum);
    end

    // Modulator state and registered output bit, updated every clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1    <= '0;
            i2    <= '0;
            bit_q <= 1'b0;
        end else begin
            i1    <= i1_n;
            i2    <= i2_n;
            bit_q <= ~i2_n[ACC_WIDTH-1];
        end
    end

endmodule

// File: tb/tb_sdm_modulator.sv
// Self-checking bench for sdm_modulator: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a sample-queue reference model.
module tb_sdm_modulator;

    localparam int DW      = 16;
    localparam int OSR     = 64;
    localparam int AW      = 20;
    localparam int FS      = 1 << (DW - 1);
    localparam int ACC_MAX = (1 << (AW - 1)) - 1;
    localparam int ACC_MIN = -(1 << (AW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;

    sdm_modulator_if #(.DATA_WIDTH(DW)) bus ();

    sdm_modulator #(
        .DATA_WIDTH(DW),
        .OSR       (OSR),
        .ACC_WIDTH (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: integrators as plain integers, pending samples in a queue.
    int m_i1, m_i2, m_bit, m_cur, m_cnt;
    int m_pending[$];

    int ones, unders;
    int obs_ready, obs_und, last_bit;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > ACC_MAX) return ACC_MAX;
        if (v < ACC_MIN) return ACC_MIN;
        return v;
    endfunction

    task automatic model_reset();
        m_i1 = 0; m_i2 = 0; m_bit = 0; m_cur = 0; m_cnt = 0;
        m_pending.delete();
    endtask

    // One clk: called just after a negedge; drives inputs, checks the
    // combinational outputs, lets the edge happen, then checks bit_out.
    task automatic step(input bit v, input int d);
        int  fb, i1n, i2n;
        bit  tick, rdy, acc, und;
        logic signed [DW-1:0] dd;
        dd = d[DW-1:0];
        bus.valid_in = v;
        bus.din      = dd;
        #1;
        tick = (m_cnt == OSR - 1);
        rdy  = (m_pending.size() == 0) || tick;
        acc  = v && rdy;
        und  = tick && (m_pending.size() == 0) && !acc;
        obs_ready = int'(bus.ready_out);
        obs_und   = int'(bus.underrun);
        check("ready_out",   int'(bus.ready_out),   int'(rdy));
        check("sample_tick", int'(bus.sample_tick), int'(tick));
        check("underrun",    int'(bus.underrun),    int'(und));
        unders += int'(bus.underrun);
        @(posedge clk);
        fb  = (m_bit != 0) ? FS : -FS;
        i1n = clamp(m_i1 + m_cur - fb);
        i2n = clamp(m_i2 + i1n - fb);
        m_i1  = i1n;
        m_i2  = i2n;
        m_bit = (i2n >= 0) ? 1 : 0;
        if (tick) begin
            if (m_pending.size() != 0) begin
                m_cur = m_pending.pop_front();
                if (acc) m_pending.push_back(int'(dd));
            end else if (acc) begin
                m_cur = int'(dd);
            end
        end else if (acc) begin
            m_pending.push_back(int'(dd));
        end
        m_cnt = (m_cnt + 1) % OSR;
        #1;
        check("bit_out", int'(bus.bit_out), m_bit);
        ones    += int'(bus.bit_out);
        last_bit = int'(bus.bit_out);
        @(negedge clk);
    endtask

    // Asynchronous reset raised mid-cycle; called just after a negedge.
    task automatic apply_reset();
        #2;
        rst = 1'b1;
        bus.valid_in = 1'b0;
        #1;
        check("rst_bit_out",     int'(bus.bit_out),     0);
        check("rst_ready_out",   int'(bus.ready_out),   1);
        check("rst_sample_tick", int'(bus.sample_tick), 0);
        check("rst_underrun",    int'(bus.underrun),    0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_cnt(input int target, input bit v, input int d);
        for (int k = 0; k < 2 * OSR && m_cnt != target; k++) step(v, d);
        if (m_cnt != target) check("frame_sync_timeout", m_cnt, target);
    endtask

    task automatic check_idle_pattern(input string tag);
        int exp_bits[4];
        exp_bits = '{1, 1, 0, 1};
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 0);
            check(tag, last_bit, exp_bits[k]);
        end
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.din      = '0;
        ones = 0; unders = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Idle pattern and underrun at every frame end.
        unders = 0;
        check_idle_pattern("idle_bits");
        for (int k = 4; k < 2 * OSR; k++) step(1'b0, 0);
        check("idle_underruns", unders, 2);

        // +FS/2 density.
        apply_reset();
        unders = 0;
        for (int k = 0; k < OSR; k++) step(1'b1, 16384);
        ones = 0;
        for (int k = 0; k < 1024; k++) step(1'b1, 16384);
        check("pos_half_density_ok", int'(ones >= 764 && ones <= 772), 1);
        check("pos_half_no_underrun", unders, 0);

        // -FS/2 density.
        apply_reset();
        unders = 0;
        for (int k = 0; k < OSR; k++) step(1'b1, -16384);
        ones = 0;
        for (int k = 0; k < 1024; k++) step(1'b1, -16384);
        check("neg_half_density_ok", int'(ones >= 252 && ones <= 260), 1);
        check("neg_half_no_underrun", unders, 0);

        // Back-to-back A then B: A held, B accepted on the tick.
        run_until_cnt(OSR - 1, 1'b0, 0);
        step(1'b0, 0);
        step(1'b1, 3000);
        check("hs_a_ready", obs_ready, 1);
        while (m_cnt != OSR - 1) begin
            step(1'b1, -5000);
            check("hs_blocked", obs_ready, 0);
        end
        step(1'b1, -5000);
        check("hs_tick_ready", obs_ready, 1);
        step(1'b1, 7777);
        check("hs_still_full", obs_ready, 0);

        // Starvation: one underrun, then a bypass load on the tick.
        run_until_cnt(OSR - 1, 1'b0, 0);
        step(1'b0, 0);
        step(1'b1, 8192);
        run_until_cnt(OSR - 1, 1'b0, 0);
        step(1'b0, 0);
        unders = 0;
        for (int k = 0; k < OSR; k++) step(1'b0, 0);
        check("starve_underruns", unders, 1);
        run_until_cnt(OSR - 1, 1'b0, 0);
        step(1'b1, -8192);
        check("bypass_ready", obs_ready, 1);
        check("bypass_no_underrun", obs_und, 0);
        step(1'b1, 1000);
        check("bypass_hold_empty", obs_ready, 1);

        // Randomized traffic within the stable input range.
        for (int k = 0; k < 40 * OSR; k++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 49152) - 24576);
        end

        // Full-scale input drives the integrators into the clamp.
        apply_reset();
        for (int k = 0; k < OSR; k++) step(1'b1, 32767);
        ones = 0;
        for (int k = 0; k < 1024; k++) step(1'b1, 32767);
        check("full_scale_density_ok", int'(ones >= 973), 1);
        for (int k = 0; k < 21; k++) step(1'b1, 32767);
        apply_reset();
        check_idle_pattern("post_reset_bits");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
